// File: rtl/seq_control_unit_if.sv
// ============================================================================
// Module   : seq_control_unit_if
// Brief    : Handshake and datapath-control bundle for seq_control_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_control_unit_if #(
    parameter int NUM_REGS   = 8,
    parameter int REG_ADDR_W = 3
);
    logic                      run;
    logic [3+2*REG_ADDR_W-1:0] instruction;
    logic                      alu_zero;
    logic                      busy;
    logic                      done;
    logic                      illegal;
    logic                      ir_load;
    logic [NUM_REGS-1:0]       reg_write_en;
    logic [1:0]                bus_src;
    logic [REG_ADDR_W-1:0]     bus_reg_sel;
    logic                      a_load;
    logic                      g_load;
    logic [1:0]                alu_op;

    modport master (
        output run, instruction, alu_zero,
        input  busy, done, illegal, ir_load, reg_write_en,
               bus_src, bus_reg_sel, a_load, g_load, alu_op
    );

    modport slave (
        input  run, instruction, alu_zero,
        output busy, done, illegal, ir_load, reg_write_en,
               bus_src, bus_reg_sel, a_load, g_load, alu_op
    );
endinterface

`default_nettype wire

// File: rtl/seq_control_unit.sv
// ============================================================================
// Module   : seq_control_unit
// Brief    : Multi-cycle instruction sequencer for the didactic datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_control_unit #(
    parameter int NUM_REGS   = 8,
    parameter int REG_ADDR_W = 3
) (
    input  wire logic         clock,
    input  wire logic         reset,
    seq_control_unit_if.slave ctrl
);
    localparam int                  c_IW       = 3 + 2*REG_ADDR_W;
    localparam logic [REG_ADDR_W:0] c_NREGS    = (REG_ADDR_W+1)'(NUM_REGS);
    localparam logic [2:0]          c_OP_MOV   = 3'd0;
    localparam logic [2:0]          c_OP_MOVI  = 3'd1;
    localparam logic [2:0]          c_OP_ADD   = 3'd2;
    localparam logic [2:0]          c_OP_SUB   = 3'd3;
    localparam logic [2:0]          c_OP_AND   = 3'd4;
    localparam logic [2:0]          c_OP_XOR   = 3'd5;
    localparam logic [2:0]          c_OP_MVNZ  = 3'd6;
    localparam logic [2:0]          c_OP_RSV   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_ir;

    logic [2:0]            w_op;
    logic [REG_ADDR_W-1:0] w_rx;
    logic [REG_ADDR_W-1:0] w_ry;
    logic                  w_bad;
    logic                  w_single;
    logic                  w_final;
    logic                  w_ir_load;

    assign w_op = r_ir[c_IW-1 -: 3];
    assign w_rx = r_ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_ry = r_ir[REG_ADDR_W-1:0];

    // Bad operands collapse any opcode to a single reporting cycle.
    assign w_bad     = (w_op == c_OP_RSV) || ({1'b0, w_rx} >= c_NREGS) ||
                       ({1'b0, w_ry} >= c_NREGS);
    assign w_single  = w_bad || (w_op == c_OP_MOV) || (w_op == c_OP_MOVI) ||
                       (w_op == c_OP_MVNZ);
    assign w_final   = ((r_state == S_T1) && w_single) || (r_state == S_T3);
    assign w_ir_load = ctrl.run && !reset && ((r_state == S_IDLE) || w_final);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else if (w_ir_load) begin
            r_state <= S_T1;
            r_ir    <= ctrl.instruction;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_IDLE;
                S_T1:    r_state <= w_single ? S_IDLE : S_T2;
                S_T2:    r_state <= S_T3;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic                  w_we;
    logic [NUM_REGS-1:0]   w_we_vec;
    logic [1:0]            w_src;
    logic [REG_ADDR_W-1:0] w_sel;
    logic                  w_a_load;
    logic                  w_g_load;
    logic [1:0]            w_alu_op;

    always_comb begin
        w_we     = 1'b0;
        w_src    = 2'b00;
        w_sel    = '0;
        w_a_load = 1'b0;
        w_g_load = 1'b0;
        w_alu_op = 2'b00;
        case (r_state)
            S_T1: begin
                if (!w_bad) begin
                    case (w_op)
                        c_OP_MOV: begin
                            w_we  = 1'b1;
                            w_sel = w_ry;
                        end
                        c_OP_MOVI: begin
                            w_we  = 1'b1;
                            w_src = 2'b01;
                        end
                        c_OP_MVNZ: begin
                            w_we  = !ctrl.alu_zero;
                            w_sel = w_ry;
                        end
                        default: begin
                            w_sel    = w_rx;
                            w_a_load = 1'b1;
                        end
                    endcase
                end
            end
            S_T2: begin
                w_sel    = w_ry;
                w_g_load = 1'b1;
                case (w_op)
                    c_OP_SUB: w_alu_op = 2'b01;
                    c_OP_AND: w_alu_op = 2'b10;
                    c_OP_XOR: w_alu_op = 2'b11;
                    default:  w_alu_op = 2'b00;
                endcase
            end
            S_T3: begin
                w_src = 2'b10;
                w_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_we_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_we_vec[i] = w_we && (w_rx == REG_ADDR_W'(i));
        end
    end

    assign ctrl.busy         = (r_state != S_IDLE);
    assign ctrl.done         = w_final;
    assign ctrl.illegal      = (r_state == S_T1) && w_bad;
    assign ctrl.ir_load      = w_ir_load;
    assign ctrl.reg_write_en = w_we_vec;
    assign ctrl.bus_src      = w_src;
    assign ctrl.bus_reg_sel  = w_sel;
    assign ctrl.a_load       = w_a_load;
    assign ctrl.g_load       = w_g_load;
    assign ctrl.alu_op       = w_alu_op;
endmodule

`default_nettype wire

// File: tb/tb_seq_control_unit.sv
// ============================================================================
// Module   : tb_seq_control_unit
// Brief    : Scoreboard bench for seq_control_unit (8-reg and 6-reg instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_control_unit;
    logic clk;
    logic rst;

    seq_control_unit_if #(.NUM_REGS(8), .REG_ADDR_W(3)) ifa ();
    seq_control_unit_if #(.NUM_REGS(6), .REG_ADDR_W(3)) ifb ();

    seq_control_unit #(.NUM_REGS(8), .REG_ADDR_W(3)) u_dut_a (
        .clock (clk),
        .reset (rst),
        .ctrl  (ifa.slave)
    );

    seq_control_unit #(.NUM_REGS(6), .REG_ADDR_W(3)) u_dut_b (
        .clock (clk),
        .reset (rst),
        .ctrl  (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          dsel;
        logic [20:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nid      = 0;
    bit   r_finished = 1'b0;

    // Snapshot layout: {busy, done, illegal, ir_load, we[7:0], src, sel, a, g, alu_op}
    function automatic logic [20:0] E(input logic b, input logic d, input logic il,
                                      input logic irl, input logic [7:0] we,
                                      input logic [1:0] src, input logic [2:0] sel,
                                      input logic a, input logic g, input logic [1:0] op);
        return {b, d, il, irl, we, src, sel, a, g, op};
    endfunction

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] rx,
                                       input logic [2:0] ry);
        return {op, rx, ry};
    endfunction

    logic [20:0] act_a;
    logic [20:0] act_b;
    assign act_a = {ifa.busy, ifa.done, ifa.illegal, ifa.ir_load, ifa.reg_write_en,
                    ifa.bus_src, ifa.bus_reg_sel, ifa.a_load, ifa.g_load, ifa.alu_op};
    assign act_b = {ifb.busy, ifb.done, ifb.illegal, ifb.ir_load, 2'b00, ifb.reg_write_en,
                    ifb.bus_src, ifb.bus_reg_sel, ifb.a_load, ifb.g_load, ifb.alu_op};

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [20:0] act;
            c      = q.pop_front();
            act    = c.dsel ? act_b : act_a;
            checks = checks + 1;
            if (act !== c.exp) begin
                failures = failures + 1;
                $display("FAIL chk%0d dut%0d outputs: actual=%h required=%h",
                         c.id, c.dsel, act, c.exp);
            end
        end
    end

    initial begin
        repeat (2000) @(posedge clk);
        if (!r_finished) begin
            failures = failures + 1;
            $display("FAIL timeout: sequence did not complete within 2000 cycles");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic step(input logic r, input logic rn, input logic [8:0] in,
                        input logic az, input bit chk, input bit ds, input logic [20:0] e);
        chk_t c;
        @(posedge clk);
        #1;
        rst             = r;
        ifa.run         = rn;
        ifb.run         = rn;
        ifa.instruction = in;
        ifb.instruction = in;
        ifa.alu_zero    = az;
        ifb.alu_zero    = az;
        if (chk) begin
            c.id   = nid;
            c.dsel = ds;
            c.exp  = e;
            nid    = nid + 1;
            q.push_back(c);
        end
    endtask

    logic [20:0] Z;
    logic [20:0] LD;
    logic [2:0]  arx [5];
    logic [2:0]  ary [5];

    initial begin
        Z   = '0;
        LD  = E(0, 0, 0, 1, 8'h00, 2'd0, 3'd0, 0, 0, 2'd0);
        arx = '{3'd2, 3'd3, 3'd5, 3'd1, 3'd0};
        ary = '{3'd6, 3'd4, 3'd0, 3'd7, 3'd0};
        rst             = 1'b1;
        ifa.run         = 1'b0;
        ifb.run         = 1'b0;
        ifa.instruction = '0;
        ifb.instruction = '0;
        ifa.alu_zero    = 1'b0;
        ifb.alu_zero    = 1'b0;

        // Reset state
        step(1, 0, 9'd0, 0, 0, 0, Z);
        step(1, 0, 9'd0, 0, 1, 0, Z);
        step(0, 0, 9'd0, 0, 1, 0, Z);

        // mov r3,r5 then movi r7 back to back
        step(0, 1, ins(3'd0, 3'd3, 3'd5), 0, 1, 0, LD);
        step(0, 1, ins(3'd1, 3'd7, 3'd0), 0, 1, 0, E(1, 1, 0, 1, 8'h08, 2'd0, 3'd5, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, E(1, 1, 0, 0, 8'h80, 2'd1, 3'd0, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, Z);

        // add, sub, and, xor chained; run pulses in first add's T1/T2 are ignored
        step(0, 1, ins(3'd2, arx[0], ary[0]), 0, 1, 0, LD);
        for (int k = 0; k < 4; k++) begin
            logic nxt;
            nxt = (k < 3);
            step(0, k == 0, ins(3'd0, 3'd1, 3'd0), 0, 1, 0,
                 E(1, 0, 0, 0, 8'h00, 2'd0, arx[k], 1, 0, 2'd0));
            step(0, k == 0, ins(3'd1, 3'd4, 3'd4), 0, 1, 0,
                 E(1, 0, 0, 0, 8'h00, 2'd0, ary[k], 0, 1, 2'(k)));
            step(0, nxt, nxt ? ins(3'(3 + k), arx[k+1], ary[k+1]) : 9'd0, 0, 1, 0,
                 E(1, 1, 0, nxt, 8'(8'h01 << arx[k]), 2'd2, 3'd0, 0, 0, 2'd0));
        end
        step(0, 0, 9'd0, 0, 1, 0, Z);

        // mvnz r4,r1 with alu_zero=1 then alu_zero=0
        step(0, 1, ins(3'd6, 3'd4, 3'd1), 1, 1, 0, LD);
        step(0, 1, ins(3'd6, 3'd4, 3'd1), 1, 1, 0, E(1, 1, 0, 1, 8'h00, 2'd0, 3'd1, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, E(1, 1, 0, 0, 8'h10, 2'd0, 3'd1, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, Z);

        // Reserved opcode
        step(0, 1, ins(3'd7, 3'd2, 3'd3), 0, 1, 0, LD);
        step(0, 0, 9'd0, 0, 1, 0, E(1, 1, 1, 0, 8'h00, 2'd0, 3'd0, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, Z);

        // 6-register instance: mov r7,r0 (bad rx), mov r5,r0 (legal), mov r2,r6 (bad ry)
        step(0, 1, ins(3'd0, 3'd7, 3'd0), 0, 1, 1, LD);
        step(0, 1, ins(3'd0, 3'd5, 3'd0), 0, 1, 1, E(1, 1, 1, 1, 8'h00, 2'd0, 3'd0, 0, 0, 2'd0));
        step(0, 1, ins(3'd0, 3'd2, 3'd6), 0, 1, 1, E(1, 1, 0, 1, 8'h20, 2'd0, 3'd0, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 1, E(1, 1, 1, 0, 8'h00, 2'd0, 3'd0, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 1, Z);

        // Reset during add T2, held 2 cycles with run high in the second
        step(0, 1, ins(3'd2, 3'd2, 3'd6), 0, 1, 0, LD);
        step(0, 0, 9'd0, 0, 1, 0, E(1, 0, 0, 0, 8'h00, 2'd0, 3'd2, 1, 0, 2'd0));
        step(1, 0, 9'd0, 0, 1, 0, E(1, 0, 0, 0, 8'h00, 2'd0, 3'd6, 0, 1, 2'd0));
        step(1, 1, ins(3'd0, 3'd1, 3'd2), 0, 1, 0, Z);
        step(0, 0, 9'd0, 0, 1, 0, Z);
        checks = checks + 1;
        if ((u_dut_a.r_ir !== '0) || (u_dut_b.r_ir !== '0)) begin
            failures = failures + 1;
            $display("FAIL reset IR: dut0=%h dut1=%h required=0",
                     u_dut_a.r_ir, u_dut_b.r_ir);
        end
        step(0, 0, 9'd0, 0, 1, 0, Z);
        step(0, 1, ins(3'd0, 3'd1, 3'd2), 0, 1, 0, LD);
        step(0, 0, 9'd0, 0, 1, 0, E(1, 1, 0, 0, 8'h02, 2'd0, 3'd2, 0, 0, 2'd0));
        step(0, 0, 9'd0, 0, 1, 0, Z);

        @(negedge clk);
        #1;
        r_finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
